// File: rtl/boot_burst_fetch_if.sv
// Request/stream side and Wishbone initiator side of the boot line fetcher.
// master is the fetcher's view; slave is the requester-plus-responder view.
interface boot_burst_fetch_if #(
  parameter int WID = 64
);
  logic           req_i;
  logic [17:0]    req_adr_i;
  logic           busy_o;
  logic           rd_vld_o;
  logic [2:0]     rd_idx_o;
  logic [WID-1:0] rd_dat_o;
  logic           done_o;
  logic           err_o;
  logic           cs_o;
  logic           cyc_o;
  logic           stb_o;
  logic [2:0]     cti_o;
  logic [17:0]    adr_o;
  logic           bok_i;
  logic           ack_i;
  logic [WID-1:0] dat_i;

  modport master (
    input  req_i, req_adr_i, bok_i, ack_i, dat_i,
    output busy_o, rd_vld_o, rd_idx_o, rd_dat_o, done_o, err_o,
           cs_o, cyc_o, stb_o, cti_o, adr_o
  );

  modport slave (
    output req_i, req_adr_i, bok_i, ack_i, dat_i,
    input  busy_o, rd_vld_o, rd_idx_o, rd_dat_o, done_o, err_o,
           cs_o, cyc_o, stb_o, cti_o, adr_o
  );
endinterface

// File: rtl/boot_burst_fetch.sv
// Fetches one aligned BEATS-word line over Wishbone (incrementing burst, or classic cycles if bok_i=0);
// words stream out one cycle after each ack, no output backpressure. BOOT_FETCH_TIMEOUT_EN adds an ack timeout abort.
module boot_burst_fetch #(
  parameter int WID   = 64,
  parameter int BEATS = 4,
  parameter int TMO   = 255
) (
  input  logic                clk_i,
  input  logic                rst_i,
  boot_burst_fetch_if.master  bus
);

  localparam int          ALO   = 3 + $clog2(BEATS);
  localparam logic [17:0] AMASK = ~18'((1 << ALO) - 1);
  localparam logic [2:0]  LAST  = 3'(BEATS - 1);
  localparam logic [2:0]  CTI_CLASSIC = 3'b000;
  localparam logic [2:0]  CTI_INCR    = 3'b010;
  localparam logic [2:0]  CTI_END     = 3'b111;

  typedef enum logic [2:0] {IDLE, START, BURST, SINGLE, SGAP} state_t;

  state_t         state_q, state_n;
  logic [2:0]     beat_q, beat_n;
  logic [17:0]    adr_q, adr_n;
  logic [2:0]     cti_q, cti_n;
  logic           cyc_q, cyc_n;
  logic           busy_q, busy_n;
  logic           vld_q, vld_n;
  logic [2:0]     idx_q, idx_n;
  logic [WID-1:0] dat_q, dat_n;
  logic           done_q, done_n;
  logic           err_q, err_n;
  logic           take_ack;
  logic           burst_mode;

`ifdef BOOT_FETCH_TIMEOUT_EN
  logic [7:0] tmo_q, tmo_n;
  logic       tmo_hit;
`else
  logic unused_tmo;
  assign unused_tmo = ^8'(TMO);
`endif

  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      state_q <= IDLE;
      beat_q  <= '0;
      adr_q   <= '0;
      cti_q   <= '0;
      cyc_q   <= 1'b0;
      busy_q  <= 1'b0;
      vld_q   <= 1'b0;
      idx_q   <= '0;
      dat_q   <= '0;
      done_q  <= 1'b0;
      err_q   <= 1'b0;
`ifdef BOOT_FETCH_TIMEOUT_EN
      tmo_q   <= '0;
`endif
    end else begin
      state_q <= state_n;
      beat_q  <= beat_n;
      adr_q   <= adr_n;
      cti_q   <= cti_n;
      cyc_q   <= cyc_n;
      busy_q  <= busy_n;
      vld_q   <= vld_n;
      idx_q   <= idx_n;
      dat_q   <= dat_n;
      done_q  <= done_n;
      err_q   <= err_n;
`ifdef BOOT_FETCH_TIMEOUT_EN
      tmo_q   <= tmo_n;
`endif
    end
  end

  always_comb begin
    state_n    = state_q;
    beat_n     = beat_q;
    adr_n      = adr_q;
    cti_n      = cti_q;
    cyc_n      = cyc_q;
    busy_n     = busy_q;
    vld_n      = 1'b0;
    idx_n      = idx_q;
    dat_n      = dat_q;
    done_n     = 1'b0;
    err_n      = 1'b0;
    take_ack   = cyc_q && bus.ack_i;
    burst_mode = (state_q == BURST) || (state_q == START && bus.bok_i);

    // busy stays up through the done/err cycle, so IDLE also waits for it to clear
    if (done_q || err_q) busy_n = 1'b0;

    case (state_q)
      IDLE: begin
        if (bus.req_i && !busy_q) begin
          state_n = START;
          cyc_n   = 1'b1;
          busy_n  = 1'b1;
          beat_n  = '0;
          adr_n   = bus.req_adr_i & AMASK;
          cti_n   = (BEATS == 1) ? CTI_CLASSIC : CTI_INCR;
        end
      end
      START: begin
        if (bus.bok_i) begin
          state_n = BURST;
        end else begin
          state_n = SINGLE;
          cti_n   = CTI_CLASSIC;
        end
      end
      SGAP: begin
        state_n = SINGLE;
        cyc_n   = 1'b1;
      end
      default: ;
    endcase

    if (take_ack) begin
      vld_n = 1'b1;
      idx_n = beat_q;
      dat_n = bus.dat_i;
      if (beat_q == LAST) begin
        state_n = IDLE;
        cyc_n   = 1'b0;
        done_n  = 1'b1;
      end else begin
        beat_n = beat_q + 3'd1;
        adr_n  = adr_q + 18'd8;
        if (burst_mode) begin
          state_n = BURST;
          cti_n   = (beat_q + 3'd1 == LAST) ? CTI_END : CTI_INCR;
        end else begin
          // drop the strobes for one cycle so the responder sees a new cycle
          state_n = SGAP;
          cyc_n   = 1'b0;
        end
      end
    end

`ifdef BOOT_FETCH_TIMEOUT_EN
    tmo_n   = tmo_q;
    tmo_hit = 1'b0;
    if (cyc_q && !bus.ack_i) begin
      if (tmo_q == 8'(TMO - 1)) tmo_hit = 1'b1;
      else                      tmo_n   = tmo_q + 8'd1;
    end
    if (take_ack || (state_n != state_q && (state_n == START || state_n == SINGLE)))
      tmo_n = '0;
    if (tmo_hit) begin
      state_n = IDLE;
      cyc_n   = 1'b0;
      err_n   = 1'b1;
      tmo_n   = '0;
    end
`endif
  end

  assign bus.busy_o   = busy_q;
  assign bus.rd_vld_o = vld_q;
  assign bus.rd_idx_o = idx_q;
  assign bus.rd_dat_o = dat_q;
  assign bus.done_o   = done_q;
  assign bus.err_o    = err_q;
  assign bus.cs_o     = cyc_q;
  assign bus.cyc_o    = cyc_q;
  assign bus.stb_o    = cyc_q;
  assign bus.cti_o    = cti_q;
  assign bus.adr_o    = adr_q;

endmodule

// File: tb/tb_boot_burst_fetch.sv
// Directed bench for boot_burst_fetch: burst, classic fallback, ack gaps, req while busy, async reset, timeout.
module tb_boot_burst_fetch;
  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  boot_burst_fetch_if #(.WID(64)) bif();

  boot_burst_fetch #(.WID(64), .BEATS(4), .TMO(10)) dut (
    .clk_i (clk),
    .rst_i (rst_n),
    .bus   (bif.master)
  );

  int n_cmp = 0;
  int n_bad = 0;
  int nvld  = 0;
  int ndone = 0;
  int nerr  = 0;

  logic [63:0] d    [4] = '{64'hA5A5_0000_1111_0001, 64'h5A5A_2222_3333_0002,
                            64'hDEAD_BEEF_4444_0003, 64'h0123_4567_89AB_CDEF};
  logic [17:0] eadr [4] = '{18'h00120, 18'h00128, 18'h00130, 18'h00138};
  logic [2:0]  ecti [4] = '{3'b010, 3'b010, 3'b010, 3'b111};

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
    if (bif.rd_vld_o) nvld++;
    if (bif.done_o)   ndone++;
    if (bif.err_o)    nerr++;
  endtask

  initial begin
    rst_n         = 1'b0;
    bif.req_i     = 1'b0;
    bif.req_adr_i = '0;
    bif.bok_i     = 1'b0;
    bif.ack_i     = 1'b0;
    bif.dat_i     = '0;
    @(posedge clk);
    #1;
    chk("rst_cyc",  bif.cyc_o, 0);
    chk("rst_stb",  bif.stb_o, 0);
    chk("rst_cs",   bif.cs_o, 0);
    chk("rst_busy", bif.busy_o, 0);
    chk("rst_vld",  bif.rd_vld_o, 0);
    chk("rst_done", bif.done_o, 0);
    chk("rst_err",  bif.err_o, 0);
    chk("rst_adr",  bif.adr_o, 0);
    chk("rst_cti",  bif.cti_o, 0);
    #3 rst_n = 1'b1;
    tick();

    // burst fetch, acks arriving on the third strobe cycle
    nvld = 0; ndone = 0;
    bif.req_i = 1'b1; bif.req_adr_i = 18'h00123; bif.bok_i = 1'b1;
    tick();
    bif.req_i = 1'b0;
    chk("b_cyc",  bif.cyc_o, 1);
    chk("b_stb",  bif.stb_o, 1);
    chk("b_cs",   bif.cs_o, 1);
    chk("b_busy", bif.busy_o, 1);
    chk("b_adr0", bif.adr_o, 18'h00120);
    tick();
    tick();
    for (int i = 0; i < 4; i++) begin
      bif.ack_i = 1'b1; bif.dat_i = d[i];
      chk("b_adr", bif.adr_o, eadr[i]);
      chk("b_cti", bif.cti_o, ecti[i]);
      tick();
      chk("b_vld",  bif.rd_vld_o, 1);
      chk("b_idx",  bif.rd_idx_o, i);
      chk("b_dat",  bif.rd_dat_o, d[i]);
      chk("b_done", bif.done_o, i == 3);
    end
    bif.ack_i = 1'b0;
    chk("b_cyc_end",  bif.cyc_o, 0);
    chk("b_stb_end",  bif.stb_o, 0);
    chk("b_busy_dn",  bif.busy_o, 1);
    tick();
    chk("b_busy_off", bif.busy_o, 0);
    chk("b_done_off", bif.done_o, 0);
    chk("b_nvld",  nvld, 4);
    chk("b_ndone", ndone, 1);

    // classic fallback, ack held high through the gaps
    nvld = 0; ndone = 0;
    bif.req_i = 1'b1; bif.req_adr_i = 18'h0013F; bif.bok_i = 1'b0;
    tick();
    bif.req_i = 1'b0;
    chk("c_cti_start", bif.cti_o, 3'b010);
    tick();
    chk("c_cti_single", bif.cti_o, 3'b000);
    for (int i = 0; i < 4; i++) begin
      bif.ack_i = 1'b1; bif.dat_i = ~d[i];
      chk("c_cyc", bif.cyc_o, 1);
      chk("c_adr", bif.adr_o, eadr[i]);
      chk("c_cti", bif.cti_o, 3'b000);
      tick();
      chk("c_vld", bif.rd_vld_o, 1);
      chk("c_idx", bif.rd_idx_o, i);
      chk("c_dat", bif.rd_dat_o, ~d[i]);
      if (i < 3) begin
        chk("c_gap_cyc", bif.cyc_o, 0);
        bif.dat_i = 64'hBAD0_BAD0_BAD0_BAD0;
        tick();
        chk("c_gap_ignored", bif.rd_vld_o, 0);
        chk("c_gap_one", bif.cyc_o, 1);
      end else begin
        chk("c_done", bif.done_o, 1);
        chk("c_cyc_end", bif.cyc_o, 0);
      end
    end
    bif.ack_i = 1'b0;
    tick();
    chk("c_busy_off", bif.busy_o, 0);
    chk("c_nvld",  nvld, 4);
    chk("c_ndone", ndone, 1);

    // ack gaps inside a burst plus a second request while busy
    nvld = 0; ndone = 0;
    bif.req_i = 1'b1; bif.req_adr_i = 18'h00140; bif.bok_i = 1'b1;
    tick();
    bif.req_i = 1'b0;
    tick();
    bif.req_i = 1'b1; bif.req_adr_i = 18'h01000;
    tick();
    bif.req_i = 1'b0;
    chk("g_adr_hold", bif.adr_o, 18'h00140);
    for (int i = 0; i < 2; i++) begin
      bif.ack_i = 1'b1; bif.dat_i = d[i];
      tick();
      chk("g_idx", bif.rd_idx_o, i);
    end
    bif.ack_i = 1'b0;
    for (int g = 0; g < 2; g++) begin
      tick();
      chk("g_gap_vld", bif.rd_vld_o, 0);
      chk("g_gap_adr", bif.adr_o, 18'h00150);
    end
    for (int i = 2; i < 4; i++) begin
      bif.ack_i = 1'b1; bif.dat_i = d[i];
      chk("g_adr", bif.adr_o, 18'h00140 + 18'(8 * i));
      tick();
      chk("g_idx", bif.rd_idx_o, i);
      chk("g_dat", bif.rd_dat_o, d[i]);
    end
    bif.ack_i = 1'b0;
    tick(); tick(); tick();
    chk("g_nvld",  nvld, 4);
    chk("g_ndone", ndone, 1);
    chk("g_no_requeue", bif.cyc_o, 0);
    chk("g_busy_off", bif.busy_o, 0);

    // asynchronous reset in the middle of a burst, ack in START accepted
    nvld = 0; ndone = 0;
    bif.req_i = 1'b1; bif.req_adr_i = 18'h3FFFF; bif.bok_i = 1'b1;
    tick();
    bif.req_i = 1'b0;
    bif.ack_i = 1'b1; bif.dat_i = d[0];
    tick();
    chk("r_start_ack_idx", bif.rd_idx_o, 0);
    chk("r_adr1", bif.adr_o, 18'h3FFE8);
    bif.dat_i = d[1];
    tick();
    chk("r_idx1", bif.rd_idx_o, 1);
    #2 rst_n = 1'b0;
    #1;
    chk("r_cyc",  bif.cyc_o, 0);
    chk("r_stb",  bif.stb_o, 0);
    chk("r_busy", bif.busy_o, 0);
    chk("r_vld",  bif.rd_vld_o, 0);
    bif.ack_i = 1'b0;
    #2 rst_n = 1'b1;
    tick(); tick();
    chk("r_ndone", ndone, 0);
    bif.req_i = 1'b1;
    tick();
    bif.req_i = 1'b0;
    chk("r_new_adr", bif.adr_o, 18'h3FFE0);
    for (int i = 0; i < 4; i++) begin
      bif.ack_i = 1'b1; bif.dat_i = d[3 - i];
      tick();
      chk("r_new_idx", bif.rd_idx_o, i);
      chk("r_new_dat", bif.rd_dat_o, d[3 - i]);
    end
    bif.ack_i = 1'b0;
    tick();
    chk("r_ndone2", ndone, 1);

    // responder never acks
    nerr = 0; ndone = 0;
    bif.req_i = 1'b1; bif.req_adr_i = 18'h00000; bif.bok_i = 1'b1;
    tick();
    bif.req_i = 1'b0;
`ifdef BOOT_FETCH_TIMEOUT_EN
    for (int k = 1; k < 10; k++) begin
      tick();
      chk("t_waiting", bif.cyc_o, 1);
    end
    tick();
    chk("t_cyc",  bif.cyc_o, 0);
    chk("t_stb",  bif.stb_o, 0);
    chk("t_err",  bif.err_o, 1);
    chk("t_done", bif.done_o, 0);
    chk("t_busy", bif.busy_o, 1);
    tick();
    chk("t_busy_off", bif.busy_o, 0);
    chk("t_err_off",  bif.err_o, 0);
    chk("t_nerr", nerr, 1);
`else
    repeat (300) tick();
    chk("t_cyc_hold",  bif.cyc_o, 1);
    chk("t_stb_hold",  bif.stb_o, 1);
    chk("t_busy_hold", bif.busy_o, 1);
    chk("t_nerr", nerr, 0);
    chk("t_ndone", ndone, 0);
    #2 rst_n = 1'b0;
    #1;
    chk("t_rst_cyc", bif.cyc_o, 0);
    #2 rst_n = 1'b1;
`endif
    tick();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
